muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO, and MFHI/MFLO read the `hi`/`lo` outputs directly. It sits beside the EX-stage ALU. Operand width and bits-per-iteration are parameters, and `busy` is the stall request to the hazard unit.

Parameters:
- WIDTH, 32, operand width in bits; HI/LO are each WIDTH bits.
- STEP, 1, result bits retired per iteration. Legal values are 1 and 2, and STEP must divide WIDTH. Illegal values stop elaboration with an error.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- start  in  1  issue op this cycle.
- op  in  3  muldiv op code (see package).
- rs_val  in  WIDTH  operand A (dividend / multiplicand / MTxx source).
- rt_val  in  WIDTH  operand B (divisor / multiplier).
- flush  in  1  abort any in-flight op.
- busy  out  1  registered, high while state != IDLE.
- done  out  1  one-cycle pulse when HI/LO are written by MULT/DIV.
- div_zero  out  1  one-cycle pulse with done when the divisor was 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high) sets: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0. Reset overrides everything else, including mid-operation.
- K = WIDTH/STEP.
- States: IDLE, RUN, FIX.
- Accept rule: start is accepted only when state==IDLE and flush==0. Start while busy is ignored; the pipeline must hold the instruction on busy.
- MTHI/MTLO:
  - At the accept edge, hi (or lo) <= rs_val.
  - State stays IDLE; busy=0, done=0.
  - An MFHI in the following cycle sees the new value.
- MULT/MULTU/DIV/DIVU accept edge:
  - Latch operand magnitudes. For signed ops, take the two's-complement absolute value.
  - Latch result-sign flags and clear the iteration counter.
  - Transition IDLE->RUN.
- RUN:
  - Each edge retires STEP bits: shift-add for multiply, restoring shift-subtract for divide.
  - After K edges, RUN->FIX.
- FIX (one cycle), on its exit edge:
  - Apply sign correction and write hi/lo.
  - Drive done=1 for exactly the next cycle; busy falls at the same edge.
  - FIX->IDLE.
- Latency: busy is high for K+1 cycles (33 for the defaults). hi/lo hold their old values until the FIX edge.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
- Divide result:
  - lo = quotient, truncated toward zero.
  - hi = remainder, which takes the sign of the dividend.
- Signed overflow: most-negative / -1 gives lo = most-negative and hi = 0. The value wraps with no flag.
- Divide by zero:
  - Accepted, but state stays IDLE and busy never rises.
  - done=1 and div_zero=1 for the next cycle.
  - hi/lo are unchanged.
- flush:
  - In RUN or FIX: next state IDLE, busy=0, no done, hi/lo unchanged.
  - In IDLE: suppresses a same-cycle start, including MTHI/MTLO.
- Back-to-back ops: a new start may be accepted in the cycle done is high, because state is already IDLE.
- Counter width is clog2(K)+1. The counter is not used outside RUN.

Decomposition:
- Shared package (next to the existing ALU op defines):
  - MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; codes 6 and 7 are no-ops (no state change).
  - Muldiv state encodings.
- Sub-module `muldiv_step`: combinational single-iteration datapath (STEP bits of add-or-subtract-and-shift). Instantiated once; the top module owns the FSM, counter, HI/LO and sign fixup.
- The ALU control decode maps MULT/DIV/MTxx to start+op.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 33 cycles, then done pulse, hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=-7 (0xFFFFFFF9), rt=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42).
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=7, rt=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV rt=0 with hi=0x11, lo=0x22 -> next cycle done=1, div_zero=1, busy never 1, hi/lo unchanged.
- MULT started, flush at RUN cycle 10 -> busy=0 next cycle, no done, hi/lo retain prior values. Start asserted mid-RUN -> ignored.
- MTLO rs=0xA5A5A5A5, then MTHI rs=0x5A5A5A5A on the next cycle -> lo and hi updated at their accept edges, busy stays 0. Reset asserted mid-DIV -> hi=lo=0, busy=0 after the edge. Repeat a MULT run with STEP=2 -> busy for 17 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op codes, state encoding and op-decode helpers for the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // Muldiv op codes; 6 and 7 are reserved and behave as no-ops
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Signed variants take absolute values on entry and fix the sign on exit
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : Combinational iteration datapath. Retires STEP result bits
//               per call: shift-add for multiply, restoring shift-subtract for
//               divide. {rem,acc} is the working register pair:
//                 multiply : rem = partial high product, acc = multiplier
//                            shifting out / product low bits shifting in
//                 divide   : rem = partial remainder, acc = dividend shifting
//                            out / quotient bits shifting in
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] acc_out
);

  localparam int W2 = 2 * WIDTH;

  // One result bit; returns {rem, acc}
  function automatic logic [W2-1:0] one_bit(
    input logic             div,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] acc
  );
    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  shifted;
    logic [WIDTH:0]  diff;
    logic [W2-1:0]   r;
    sum     = {1'b0, rem} + (acc[0] ? {1'b0, d} : {(WIDTH+1){1'b0}});
    shifted = {rem, acc[WIDTH-1]};
    diff    = shifted - {1'b0, d};
    if (div) begin
      // The partial remainder is always below the divisor, so diff's top bit
      // is a clean borrow flag: clear means the subtraction fits.
      if (!diff[WIDTH]) r = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              r = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      r = {sum, acc[WIDTH-1:1]};
    end
    return r;
  endfunction

  logic [W2-1:0] stage1;
  logic [W2-1:0] stage_last;

  assign stage1 = one_bit(is_div, opnd, rem_in, acc_in);

  if (STEP == 2) begin : g_two_bits
    assign stage_last = one_bit(is_div, opnd, stage1[W2-1:WIDTH], stage1[WIDTH-1:0]);
  end else begin : g_one_bit
    assign stage_last = stage1;
  end

  assign rem_out = stage_last[W2-1:WIDTH];
  assign acc_out = stage_last[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit with architectural HI/LO.
//               Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO; busy stalls the pipe
//               for K+1 cycles (K = WIDTH/STEP) while an op iterates.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int K     = WIDTH / STEP;
  localparam int CNT_W = $clog2(K) + 1;
  localparam int W2    = 2 * WIDTH;

  if (!((STEP == 1) || (STEP == 2)) || ((WIDTH % STEP) != 0)) begin : g_bad_step
    $error("muldiv_unit: STEP must be 1 or 2 and divide WIDTH");
  end

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_acc;
  logic [W2-1:0]    w_prod;
  logic [W2-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Operand magnitudes for the unsigned core; signed ops strip the sign here
  assign w_accept = start && !flush && (state_q == MD_IDLE);
  assign w_a_neg  = md_is_signed(op) && rs_val[WIDTH-1];
  assign w_b_neg  = md_is_signed(op) && rt_val[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (WIDTH'(0) - rs_val) : rs_val;
  assign w_b_mag  = w_b_neg ? (WIDTH'(0) - rt_val) : rt_val;

  // Sign fixup applied on the FIX exit edge
  assign w_prod     = {rem_q, acc_q};
  assign w_prod_fix = neg_lo_q ? (W2'(0) - w_prod) : w_prod;
  assign w_quot_fix = neg_lo_q ? (WIDTH'(0) - acc_q) : acc_q;
  assign w_rem_fix  = neg_hi_q ? (WIDTH'(0) - rem_q) : rem_q;

  muldiv_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .is_div  (is_div_q),
    .opnd    (opnd_q),
    .rem_in  (rem_q),
    .acc_in  (acc_q),
    .rem_out (w_step_rem),
    .acc_out (w_step_acc)
  );

  // Next-state logic: accept/decode in IDLE, iterate in RUN, write back in FIX
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (w_accept) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              rem_d    = '0;
              acc_d    = w_b_mag;
              opnd_d   = w_a_mag;
              is_div_d = 1'b0;
              neg_lo_d = w_a_neg ^ w_b_neg;
              neg_hi_d = 1'b0;
              cnt_d    = '0;
              state_d  = MD_RUN;
            end
            MD_DIV, MD_DIVU: begin
              if (rt_val == '0) begin
                // Divide by zero completes immediately and leaves HI/LO alone
                done_d = 1'b1;
                dz_d   = 1'b1;
              end else begin
                rem_d    = '0;
                acc_d    = w_a_mag;
                opnd_d   = w_b_mag;
                is_div_d = 1'b1;
                neg_lo_d = w_a_neg ^ w_b_neg;
                neg_hi_d = w_a_neg;
                cnt_d    = '0;
                state_d  = MD_RUN;
              end
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          rem_d = w_step_rem;
          acc_d = w_step_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(K - 1)) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = w_rem_fix;
            lo_d = w_quot_fix;
          end else begin
            hi_d = w_prod_fix[W2-1:WIDTH];
            lo_d = w_prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase

    busy_d = (state_d != MD_IDLE);
  end

  // State and output registers; reset wins over any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
`default_nettype wire
